branch_pred_unit: RTL and testbench



---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_btb.sv | 60 ++++++
 rtl/branch_pred_unit.sv | 120 ++++++++++++
 tb/tb_branch_pred_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Contents: control-transfer opcodes, 2-bit direction counter encoding,
// the saturating counter update and a control-transfer opcode test.
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Move a 2-bit direction counter one step toward the resolved outcome,
  // holding at the strong states.
  function automatic ctr_t ctr_sat_update(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

  function automatic logic is_cti(logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valid bits)
//   i_rd_pc       lookup PC; o_hit / o_target are combinational from state
//   i_wr_en       write strobe; i_wr_pc selects entry/tag, i_wr_target stored
// A write to the entry being read becomes visible on the following cycle.
module bp_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic [XLEN-1:0] i_wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_unused;

  assign w_rd_idx = i_rd_pc[IDX_W+1:2];
  assign w_rd_tag = i_rd_pc[XLEN-1:IDX_W+2];
  assign w_wr_idx = i_wr_pc[IDX_W+1:2];
  assign w_wr_tag = i_wr_pc[XLEN-1:IDX_W+2];
  // Instruction alignment bits never take part in indexing or tagging.
  assign w_unused = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_target = r_target[w_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch-stage branch predictor: gshare PHT, direct-mapped BTB and a
// speculative global history register with checkpoint repair.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_valid/f_stall/f_pc/f_opcode fetch lookup request
//   pred_taken/pred_target        same-cycle prediction
//   pred_ghr                      history checkpoint travelling with the insn
//   u_*                           resolution from EX/MEM (train + repair)
//   cnt_resolved/cnt_mispred      saturating accuracy counters
module branch_pred_unit
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int GHR_BITS    = 8,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_valid,
  input  logic                f_stall,
  input  logic [XLEN-1:0]     f_pc,
  input  logic [6:0]          f_opcode,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                u_valid,
  input  logic [XLEN-1:0]     u_pc,
  input  logic [6:0]          u_opcode,
  input  logic                u_taken,
  input  logic [XLEN-1:0]     u_target,
  input  logic [GHR_BITS-1:0] u_ghr,
  input  logic                u_mispredict,
  output logic [CNT_W-1:0]    cnt_resolved,
  output logic [CNT_W-1:0]    cnt_mispred
);

  localparam int PHT_N = 1 << GHR_BITS;

  logic [GHR_BITS-1:0] r_ghr;
  ctr_t                r_pht [PHT_N];
  logic [CNT_W-1:0]    r_cnt_resolved;
  logic [CNT_W-1:0]    r_cnt_mispred;

  logic [GHR_BITS-1:0] w_f_pht_idx;
  logic [GHR_BITS-1:0] w_u_pht_idx;
  logic                w_btb_hit;
  logic [XLEN-1:0]     w_btb_target;
  logic                w_btb_wr;
  logic                w_taken;

  assign w_f_pht_idx = f_pc[GHR_BITS+1:2] ^ r_ghr;
  assign w_u_pht_idx = u_pc[GHR_BITS+1:2] ^ u_ghr;
  assign w_btb_wr    = !rst && u_valid && u_taken && is_cti(u_opcode);

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_pc     (f_pc),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_wr_en     (w_btb_wr),
    .i_wr_pc     (u_pc),
    .i_wr_target (u_target)
  );

  // While rst is high the outputs present the post-reset state, so the
  // registered tables are masked rather than read.
  always_comb begin
    w_taken = 1'b0;
    if (!rst && f_valid) begin
      if (f_opcode == OPC_BRANCH) begin
        w_taken = w_btb_hit && (r_pht[w_f_pht_idx] inside {WT, ST});
      end else if ((f_opcode == OPC_JAL) || (f_opcode == OPC_JALR)) begin
        w_taken = w_btb_hit;
      end
    end
  end

  assign pred_taken   = w_taken;
  assign pred_target  = w_taken ? w_btb_target : f_pc + XLEN'(4);
  assign pred_ghr     = rst ? '0 : r_ghr;
  assign cnt_resolved = r_cnt_resolved;
  assign cnt_mispred  = r_cnt_mispred;

  // A mispredict repair outranks the speculative shift of a same-cycle fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (u_valid && u_mispredict) begin
      r_ghr <= (u_opcode == OPC_BRANCH) ? {u_ghr[GHR_BITS-2:0], u_taken} : u_ghr;
    end else if (f_valid && !f_stall && (f_opcode == OPC_BRANCH)) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], w_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= WNT;
    end else if (u_valid && (u_opcode == OPC_BRANCH)) begin
      r_pht[w_u_pht_idx] <= ctr_sat_update(r_pht[w_u_pht_idx], u_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_resolved <= '0;
      r_cnt_mispred  <= '0;
    end else begin
      if (u_valid && is_cti(u_opcode) && (r_cnt_resolved != '1))
        r_cnt_resolved <= r_cnt_resolved + CNT_W'(1);
      if (u_valid && u_mispredict && (r_cnt_mispred != '1))
        r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
module tb_branch_pred_unit;

  localparam logic [6:0] BR   = 7'h63;
  localparam logic [6:0] JAL  = 7'h6F;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [6:0] ALU  = 7'h13;

  logic        clk;
  logic        rst;
  logic        f_valid, f_stall;
  logic [31:0] f_pc;
  logic [6:0]  f_opcode;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        u_valid, u_taken, u_mispredict;
  logic [31:0] u_pc, u_target;
  logic [6:0]  u_opcode;
  logic [7:0]  u_ghr;
  logic [31:0] cnt_resolved, cnt_mispred;

  int n_checks = 0;
  int n_fail   = 0;

  branch_pred_unit #(.XLEN(32), .GHR_BITS(8), .BTB_ENTRIES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc), .f_opcode(f_opcode),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .u_valid(u_valid), .u_pc(u_pc), .u_opcode(u_opcode), .u_taken(u_taken),
    .u_target(u_target), .u_ghr(u_ghr), .u_mispredict(u_mispredict),
    .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer tables indexed by arithmetic on the PC.
  int          m_pht [256];
  bit          m_bv  [16];
  longint      m_btag [16];
  logic [31:0] m_btgt [16];
  int          m_ghr;
  longint      m_res, m_mis;

  function automatic bit is_ct(logic [6:0] op);
    return (op == BR) || (op == JAL) || (op == JALR);
  endfunction

  task automatic model_predict(output bit t, output logic [31:0] tgt);
    int bi, pi;
    bit hit;
    t = 0; bi = 0;
    if (!rst && f_valid) begin
      bi  = int'((f_pc >> 2) % 16);
      hit = m_bv[bi] && (m_btag[bi] == longint'(f_pc >> 6));
      pi  = int'((f_pc >> 2) % 256) ^ m_ghr;
      if (f_opcode == BR) t = hit && (m_pht[pi] >= 2);
      else if (f_opcode == JAL || f_opcode == JALR) t = hit;
    end
    tgt = t ? m_btgt[bi] : f_pc + 32'd4;
  endtask

  task automatic model_update(input bit pt);
    int pi, bi;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
      m_ghr = 0; m_res = 0; m_mis = 0;
    end else begin
      if (u_valid && u_mispredict)
        m_ghr = (u_opcode == BR) ? (((int'(u_ghr) * 2) + int'(u_taken)) % 256) : int'(u_ghr);
      else if (f_valid && !f_stall && f_opcode == BR)
        m_ghr = ((m_ghr * 2) + int'(pt)) % 256;
      if (u_valid && u_opcode == BR) begin
        pi = int'((u_pc >> 2) % 256) ^ int'(u_ghr);
        if (u_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
        else         m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
      end
      if (u_valid && u_taken && is_ct(u_opcode)) begin
        bi = int'((u_pc >> 2) % 16);
        m_bv[bi] = 1; m_btag[bi] = longint'(u_pc >> 6); m_btgt[bi] = u_target;
      end
      if (u_valid && is_ct(u_opcode) && m_res < 64'hFFFF_FFFF) m_res++;
      if (u_valid && u_mispredict && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Explicit constant expectations on the current lookup, taken before the edge.
  task automatic expect_pred(input string tag, input bit t, input logic [31:0] tgt);
    #1;
    check({tag, "_taken"}, 64'(pred_taken), 64'(t));
    check({tag, "_target"}, 64'(pred_target), 64'(tgt));
  endtask

  // One clock: compare the lookup against the model, clock, advance the model,
  // compare counters. Returns at posedge+1 so the caller can drive new inputs.
  task automatic step();
    bit          et;
    logic [31:0] etg;
    #1;
    model_predict(et, etg);
    check("pred_taken", 64'(pred_taken), 64'(et));
    check("pred_target", 64'(pred_target), 64'(etg));
    check("pred_ghr", 64'(pred_ghr), rst ? 64'd0 : 64'(m_ghr));
    @(posedge clk);
    model_update(et);
    #1;
    check("cnt_resolved", 64'(cnt_resolved), 64'(m_res));
    check("cnt_mispred", 64'(cnt_mispred), 64'(m_mis));
  endtask

  task automatic fetch(input bit v, input bit st, input logic [31:0] pc, input logic [6:0] op);
    f_valid = v; f_stall = st; f_pc = pc; f_opcode = op;
  endtask

  task automatic upd(input bit v, input logic [31:0] pc, input logic [6:0] op, input bit t,
                     input logic [31:0] tgt, input logic [7:0] g, input bit mis);
    u_valid = v; u_pc = pc; u_opcode = op; u_taken = t; u_target = tgt; u_ghr = g; u_mispredict = mis;
  endtask

  logic [31:0] pcs [7];

  initial begin
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h4C;
    pcs[4] = 32'h100; pcs[5] = 32'h140; pcs[6] = 32'h180;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) begin m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; end
    m_ghr = 0; m_res = 0; m_mis = 0;

    // Reset with junk resolution traffic.
    rst = 1;
    fetch(1, 0, 32'h40, BR);
    upd(1, 32'h40, JAL, 1, 32'h999, 8'hAA, 1);
    expect_pred("rst", 0, 32'h44);
    check("rst_ghr", 64'(pred_ghr), 64'h0);
    step();
    check("rst_cnt_res", 64'(cnt_resolved), 64'd0);
    check("rst_cnt_mis", 64'(cnt_mispred), 64'd0);
    rst = 0;

    // Train one taken branch, then look it up.
    fetch(0, 0, 32'h40, BR);
    upd(1, 32'h40, BR, 1, 32'h20, 8'h00, 0);
    step();
    check("train_cnt_res", 64'(cnt_resolved), 64'd1);
    fetch(1, 1, 32'h40, BR);
    upd(0, 0, ALU, 0, 0, 0, 0);
    expect_pred("train", 1, 32'h20);
    step();

    // Saturation then decay.
    fetch(0, 0, 32'h40, BR);
    upd(1, 32'h40, BR, 1, 32'h20, 8'h00, 0);
    repeat (4) step();
    fetch(1, 1, 32'h40, BR);
    upd(1, 32'h40, BR, 0, 32'h20, 8'h00, 0);
    step();
    upd(0, 0, ALU, 0, 0, 0, 0);
    expect_pred("sat_nt1", 1, 32'h20);
    upd(1, 32'h40, BR, 0, 32'h20, 8'h00, 0);
    step();
    upd(0, 0, ALU, 0, 0, 0, 0);
    expect_pred("sat_nt2", 0, 32'h44);
    step();

    // Train three branches aliasing onto the same PHT counter, then fetch them.
    fetch(0, 0, 32'h40, BR);
    upd(1, 32'h40, BR, 1, 32'h20, 8'h00, 0); step();
    upd(1, 32'h44, BR, 1, 32'h80, 8'h01, 0); step();
    upd(1, 32'h4C, BR, 1, 32'h90, 8'h03, 0); step();
    upd(0, 0, ALU, 0, 0, 0, 0);
    fetch(1, 0, 32'h40, BR); step();
    fetch(1, 0, 32'h44, BR); expect_pred("ghr_f2", 1, 32'h80); step();
    fetch(1, 0, 32'h4C, BR); expect_pred("ghr_f3", 1, 32'h90); step();
    fetch(1, 0, 32'h40, BR);
    upd(1, 32'h40, BR, 0, 32'h20, 8'h01, 1);
    #1; check("ghr_spec7", 64'(pred_ghr), 64'h07);
    step();
    upd(0, 0, ALU, 0, 0, 0, 0);
    fetch(1, 1, 32'h40, BR);
    #1; check("ghr_repair", 64'(pred_ghr), 64'h02);
    check("mis_cnt", 64'(cnt_mispred), 64'd1);
    step();
    #1; check("ghr_stall", 64'(pred_ghr), 64'h02);
    step();

    // Jump into the BTB, then an aliasing tag.
    fetch(0, 0, 32'h100, JAL);
    upd(1, 32'h100, JAL, 1, 32'h180, 8'h00, 0); step();
    upd(0, 0, ALU, 0, 0, 0, 0);
    fetch(1, 0, 32'h100, JAL); expect_pred("jal_hit", 1, 32'h180); step();
    fetch(1, 0, 32'h140, JAL); expect_pred("jal_alias", 0, 32'h144);
    check("jal_ghr", 64'(pred_ghr), 64'h02);
    step();

    // Mid-run reset with a write attempt in the same cycle.
    rst = 1;
    fetch(1, 0, 32'h100, JAL);
    upd(1, 32'h100, JAL, 1, 32'h1C0, 8'h05, 1);
    step();
    rst = 0;
    upd(0, 0, ALU, 0, 0, 0, 0);
    expect_pred("midrst", 0, 32'h104);
    check("midrst_cnt_res", 64'(cnt_resolved), 64'd0);
    check("midrst_cnt_mis", 64'(cnt_mispred), 64'd0);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [6:0] ops [4];
      ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ALU;
      rst = ($urandom_range(0, 63) == 0);
      fetch($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            pcs[$urandom_range(0, 6)], ops[$urandom_range(0, 5) % 4]);
      upd($urandom_range(0, 1), pcs[$urandom_range(0, 6)], ops[$urandom_range(0, 5) % 4],
          $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 255)),
          $urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
